// File: rtl/pulse_period_meter_if.sv
// rtl/pulse_period_meter_if.sv - measure-side bundle of the pulse period meter
// master drives enable and pulse stream; slave reports period, strobes and lock.
interface pulse_period_meter_if #(
  parameter int N = 8
);
  logic         ena;
  logic         pulse_in;
  logic [N-1:0] period;
  logic         period_valid;
  logic         timeout;
  logic         locked;

  modport master (
    output ena, pulse_in,
    input  period, period_valid, timeout, locked
  );

  modport slave (
    input  ena, pulse_in,
    output period, period_valid, timeout, locked
  );
endinterface

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures clk cycles between rising pulse edges
// reports each period with a strobe, flags counter overflow as timeout, tracks lock.
module pulse_period_meter #(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic clk,
  input  logic rst,
  pulse_period_meter_if.slave bus
);
  localparam int            MW      = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [N-1:0]  CNT_MAX = '1;
  localparam logic [N:0]    TOL_W   = (N+1)'(TOL);
  localparam logic [MW-1:0] LC_W    = MW'(LOCK_COUNT);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  period_q, period_d;
  logic [MW-1:0] match_q, match_d;
  logic          have_prev_q, have_prev_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          locked_q, locked_d;
  logic          pulse_q;

  logic          rise;
  logic [N:0]    diff;
  logic          match;
  logic [MW-1:0] match_inc;

  // pulse_q resets high so a level already high at reset release is not an edge
  assign rise      = bus.pulse_in & ~pulse_q;
  assign diff      = (cnt_q >= prev_q) ? ({1'b0, cnt_q} - {1'b0, prev_q})
                                       : ({1'b0, prev_q} - {1'b0, cnt_q});
  assign match     = (diff <= TOL_W);
  assign match_inc = (match_q >= LC_W) ? LC_W : match_q + MW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    period_d    = period_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    locked_d    = locked_q;
    if (bus.ena) begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_d       = N'(1);
            have_prev_d = 1'b0;
            state_d     = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d    = cnt_q;
            valid_d     = 1'b1;
            cnt_d       = N'(1);
            prev_d      = cnt_q;
            have_prev_d = 1'b1;
            // the first period after IDLE has nothing to compare against
            if (have_prev_q && match) match_d = match_inc;
            else                      match_d = '0;
            locked_d    = (match_d >= LC_W);
          end else if (cnt_q == CNT_MAX) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_d     = '0;
            have_prev_d = 1'b0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + N'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      period_q    <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      locked_q    <= 1'b0;
      pulse_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      period_q    <= period_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
      pulse_q     <= bus.pulse_in;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.locked       = locked_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - scoreboard bench for pulse_period_meter
// three instances cover N=8/TOL=0, N=4 timeout range and TOL=1 lock tolerance.
module tb_pulse_period_meter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_period_meter_if #(.N(8)) if0 ();
  pulse_period_meter_if #(.N(4)) if1 ();
  pulse_period_meter_if #(.N(8)) if2 ();

  pulse_period_meter #(.N(8), .LOCK_COUNT(4), .TOL(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pulse_period_meter #(.N(4), .LOCK_COUNT(4), .TOL(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pulse_period_meter #(.N(8), .LOCK_COUNT(4), .TOL(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    int cyc;
    bit to;
    int period;
    bit locked;
  } ev_t;

  ev_t  exp_q[3][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0;
  logic pv[3], tov[3], lk[3];
  logic [31:0] per[3];

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    pv[0] = if0.period_valid; tov[0] = if0.timeout; lk[0] = if0.locked; per[0] = 32'(if0.period);
    pv[1] = if1.period_valid; tov[1] = if1.timeout; lk[1] = if1.locked; per[1] = 32'(if1.period);
    pv[2] = if2.period_valid; tov[2] = if2.timeout; lk[2] = if2.locked; per[2] = 32'(if2.period);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input bit to, input int p, input bit l);
    ev_t e;
    e.cyc = c; e.to = to; e.period = p; e.locked = l;
    exp_q[d].push_back(e);
  endtask

  task automatic drive(input int d, input bit en, input bit p);
    case (d)
      0: begin if0.ena = en; if0.pulse_in = p; end
      1: begin if1.ena = en; if1.pulse_in = p; end
      default: begin if2.ena = en; if2.pulse_in = p; end
    endcase
  endtask

  // Monitor: pops one expectation per strobe; expectations whose cycle has passed are misses.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL dut%0d missed strobe: expected at cycle %0d, absent through cycle %0d", d, exp_q[d][0].cyc, cyc);
        void'(exp_q[d].pop_front());
      end
      if (pv[d] === 1'b1 || tov[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected strobe at cycle %0d: valid=%0b timeout=%0b period=%0d required none",
                   d, cyc, pv[d], tov[d], per[d]);
        end else begin
          ev_t e;
          e = exp_q[d].pop_front();
          chk($sformatf("dut%0d strobe cycle", d), cyc, e.cyc);
          chk($sformatf("dut%0d timeout", d), {31'd0, tov[d]}, {31'd0, e.to});
          chk($sformatf("dut%0d valid", d), {31'd0, pv[d]}, {31'd0, !e.to});
          if (!e.to) chk($sformatf("dut%0d period", d), per[d], e.period);
          chk($sformatf("dut%0d locked", d), {31'd0, lk[d]}, {31'd0, e.locked});
        end
      end
    end
  end

  task automatic do_reset(input bit p);
    for (int d = 0; d < 3; d++) drive(d, 1'b0, p);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_seq(input int d, input int n, input int rs[8], input int w);
    for (int r = 0; r < n; r++) begin
      bit p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) if (r >= rs[i] && r < rs[i] + w) p = 1'b1;
      drive(d, 1'b1, p);
      @(negedge clk);
    end
    drive(d, 1'b0, 1'b0);
  endtask

  task automatic expect_empty(input int d);
    chk($sformatf("dut%0d pending expectations", d), exp_q[d].size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0);
    do_reset(1'b0);
    chk("reset period", per[0], 0);
    chk("reset period_valid", {31'd0, pv[0]}, 0);
    chk("reset timeout", {31'd0, tov[0]}, 0);
    chk("reset locked", {31'd0, lk[0]}, 0);

    // steady period 5 then period change to 7
    t0 = cyc;
    push(0, t0+16, 0, 5, 0); push(0, t0+21, 0, 5, 0); push(0, t0+26, 0, 5, 0);
    push(0, t0+31, 0, 5, 0); push(0, t0+36, 0, 5, 1);
    push(0, t0+43, 0, 7, 0); push(0, t0+50, 0, 7, 0);
    run_seq(0, 56, '{10, 15, 20, 25, 30, 35, 42, 49}, 1);
    chk("period holds after run", per[0], 7);
    chk("locked after period change", {31'd0, lk[0]}, 0);
    expect_empty(0);

    // N=4 timeout, then restart from IDLE
    do_reset(1'b0);
    t0 = cyc;
    push(1, t0+16, 1, 0, 0); push(1, t0+24, 0, 3, 0);
    run_seq(1, 27, '{0, 20, 23, -100, -100, -100, -100, -100}, 1);
    expect_empty(1);

    // N=4 rise exactly at counter max is a measurement, not a timeout
    do_reset(1'b0);
    t0 = cyc;
    push(1, t0+16, 0, 15, 0);
    run_seq(1, 22, '{0, 15, -100, -100, -100, -100, -100, -100}, 1);
    expect_empty(1);

    // disabled cycles are not counted; rise while disabled never counts
    do_reset(1'b0);
    t0 = cyc;
    push(0, t0+7, 0, 3, 0);
    for (int r = 0; r < 16; r++) begin
      drive(0, !((r >= 2 && r <= 4) || r == 9), (r == 0) || (r == 6) || (r >= 9 && r <= 12));
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0);
    expect_empty(0);

    // pulse high through reset release, wide pulses, reset mid-count
    do_reset(1'b1);
    t0 = cyc;
    push(0, t0+17, 0, 8, 0); push(0, t0+25, 0, 8, 0); push(0, t0+33, 0, 8, 0);
    for (int r = 0; r < 46; r++) begin
      if (r == 37) begin
        chk("mid-reset period", per[0], 0);
        chk("mid-reset period_valid", {31'd0, pv[0]}, 0);
        chk("mid-reset timeout", {31'd0, tov[0]}, 0);
        chk("mid-reset locked", {31'd0, lk[0]}, 0);
      end
      rst = (r == 36);
      drive(0, 1'b1, (r < 2) || (r >= 8 && ((r - 8) % 8) < 3));
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0);
    expect_empty(0);

    // TOL=1 lock on alternating 5/6, drop on 8
    do_reset(1'b0);
    t0 = cyc;
    push(2, t0+6, 0, 5, 0);  push(2, t0+12, 0, 6, 0); push(2, t0+17, 0, 5, 0);
    push(2, t0+23, 0, 6, 0); push(2, t0+28, 0, 5, 1); push(2, t0+36, 0, 8, 0);
    run_seq(2, 40, '{0, 5, 11, 16, 22, 27, 35, -100}, 1);
    expect_empty(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
